// File: rtl/fifomult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifomult_pkg
//  Description : Shared types and constants for the fifomult2024 initiator
//                front end: driver state encoding, default operand/result
//                widths and the upstream response record.
//  Revision    : 1.0  initial release
// ============================================================================
package fifomult_pkg;

    // Default operand width; the multiplier result is twice as wide.
    localparam int c_data_w = 16;
    localparam int c_res_w  = 2 * c_data_w;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND_A   = 3'd1,
        S_GAP      = 3'd2,
        S_SEND_B   = 3'd3,
        S_WAIT_RES = 3'd4,
        S_RESP     = 3'd5
    } fifomult_drv_state_t;

    // Response returned upstream. A timeout carries a zero result and
    // cleared parity flags.
    typedef struct packed {
        logic [c_res_w-1:0] result;
        logic               in_perr;
        logic               out_perr;
        logic               timeout;
    } fifomult_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fifomult_driver.sv
`default_nettype none
// ============================================================================
//  Module      : fifomult_driver
//  Description : Initiator front end for the fifomult2024 multiplier. Takes
//                an operand pair from a ready/valid source, sends A then B
//                with even-XOR parity (optionally corrupted for injection),
//                waits for the result, checks its parity and hands a
//                response record back upstream.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst                  clock, synchronous active-high reset
//    req_valid/req_ready       operand handshake (ready only in IDLE)
//    req_a, req_b              signed operands
//    req_a_perr, req_b_perr    invert the parity bit sent with A / B
//    data_in*, busy_out        word interface towards the multiplier
//    data_out*, data_in_parity_error
//                              result interface from the multiplier
//    rsp_valid/rsp_ready       response handshake; fields held until taken
//    rsp_result, rsp_in_perr, rsp_out_perr, rsp_timeout
//                              response fields
//    spurious_out              pulse on a result strobe outside WAIT_RES
// ============================================================================
module fifomult_driver
    import fifomult_pkg::*;
#(
    parameter int DATA_W         = c_data_w,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    input  logic                req_a_perr,
    input  logic                req_b_perr,
    output logic [DATA_W-1:0]   data_in,
    output logic                data_in_parity,
    output logic                data_in_valid,
    input  logic                busy_out,
    input  logic [2*DATA_W-1:0] data_out,
    input  logic                data_out_parity,
    input  logic                data_out_valid,
    input  logic                data_in_parity_error,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2*DATA_W-1:0] rsp_result,
    output logic                rsp_in_perr,
    output logic                rsp_out_perr,
    output logic                rsp_timeout,
    output logic                spurious_out
);

    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    fifomult_drv_state_t r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_a, w_a_nxt;
    logic [DATA_W-1:0]   r_b, w_b_nxt;
    logic                r_a_perr, w_a_perr_nxt;
    logic                r_b_perr, w_b_perr_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_data_in, w_data_in_nxt;
    logic                r_data_in_parity, w_data_in_parity_nxt;
    logic                r_data_in_valid, w_data_in_valid_nxt;
    logic                r_req_ready, w_req_ready_nxt;
    fifomult_rsp_t       r_rsp, w_rsp_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic                r_spurious, w_spurious_nxt;

    always_comb begin
        w_state_nxt          = r_state;
        w_a_nxt              = r_a;
        w_b_nxt              = r_b;
        w_a_perr_nxt         = r_a_perr;
        w_b_perr_nxt         = r_b_perr;
        w_cnt_nxt            = r_cnt;
        w_data_in_nxt        = r_data_in;
        w_data_in_parity_nxt = r_data_in_parity;
        w_data_in_valid_nxt  = 1'b0;   // strobes last a single cycle
        w_rsp_nxt            = r_rsp;
        w_rsp_valid_nxt      = r_rsp_valid;
        w_spurious_nxt       = data_out_valid && (r_state != S_WAIT_RES);

        case (r_state)
            S_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_a_nxt      = req_a;
                    w_b_nxt      = req_b;
                    w_a_perr_nxt = req_a_perr;
                    w_b_perr_nxt = req_b_perr;
                    w_state_nxt  = S_SEND_A;
                end
            end
            S_SEND_A: begin
                if (!busy_out) begin
                    w_data_in_nxt        = r_a;
                    w_data_in_parity_nxt = (^r_a) ^ r_a_perr;
                    w_data_in_valid_nxt  = 1'b1;
                    w_state_nxt          = S_GAP;
                end
            end
            S_GAP: begin
                // One idle cycle between words so the multiplier pairs them.
                w_state_nxt = S_SEND_B;
            end
            S_SEND_B: begin
                if (!busy_out) begin
                    w_data_in_nxt        = r_b;
                    w_data_in_parity_nxt = (^r_b) ^ r_b_perr;
                    w_data_in_valid_nxt  = 1'b1;
                    w_state_nxt          = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                w_cnt_nxt = r_cnt + c_cnt_one;
                // A result arriving on the timeout edge still counts.
                if (data_out_valid) begin
                    w_rsp_nxt.result   = data_out;
                    w_rsp_nxt.in_perr  = data_in_parity_error;
                    w_rsp_nxt.out_perr = (^data_out) != data_out_parity;
                    w_rsp_nxt.timeout  = 1'b0;
                    w_rsp_valid_nxt    = 1'b1;
                    w_state_nxt        = S_RESP;
                end else if (r_cnt == c_cnt_last) begin
                    w_rsp_nxt.result   = '0;
                    w_rsp_nxt.in_perr  = 1'b0;
                    w_rsp_nxt.out_perr = 1'b0;
                    w_rsp_nxt.timeout  = 1'b1;
                    w_rsp_valid_nxt    = 1'b1;
                    w_state_nxt        = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Registered ready mirrors "next state is IDLE".
        w_req_ready_nxt = (w_state_nxt == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_a              <= '0;
            r_b              <= '0;
            r_a_perr         <= 1'b0;
            r_b_perr         <= 1'b0;
            r_cnt            <= '0;
            r_data_in        <= '0;
            r_data_in_parity <= 1'b0;
            r_data_in_valid  <= 1'b0;
            r_req_ready      <= 1'b1;
            r_rsp            <= '0;
            r_rsp_valid      <= 1'b0;
            r_spurious       <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_a              <= w_a_nxt;
            r_b              <= w_b_nxt;
            r_a_perr         <= w_a_perr_nxt;
            r_b_perr         <= w_b_perr_nxt;
            r_cnt            <= w_cnt_nxt;
            r_data_in        <= w_data_in_nxt;
            r_data_in_parity <= w_data_in_parity_nxt;
            r_data_in_valid  <= w_data_in_valid_nxt;
            r_req_ready      <= w_req_ready_nxt;
            r_rsp            <= w_rsp_nxt;
            r_rsp_valid      <= w_rsp_valid_nxt;
            r_spurious       <= w_spurious_nxt;
        end
    end

    assign req_ready      = r_req_ready;
    assign data_in        = r_data_in;
    assign data_in_parity = r_data_in_parity;
    assign data_in_valid  = r_data_in_valid;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_result     = r_rsp.result;
    assign rsp_in_perr    = r_rsp.in_perr;
    assign rsp_out_perr   = r_rsp.out_perr;
    assign rsp_timeout    = r_rsp.timeout;
    assign spurious_out   = r_spurious;

endmodule
`default_nettype wire

// File: tb/tb_fifomult_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifomult_driver
//  Description : Self-checking bench for fifomult_driver with a behavioural
//                multiplier model and strobe/response scoreboards.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifomult_driver;

    localparam int c_w  = 16;
    localparam int c_to = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready;
    logic [c_w-1:0]   req_a, req_b;
    logic             req_a_perr, req_b_perr;
    logic [c_w-1:0]   data_in;
    logic             data_in_parity, data_in_valid;
    logic             busy_out;
    logic [2*c_w-1:0] data_out;
    logic             data_out_parity, data_out_valid, data_in_parity_error;
    logic             rsp_valid, rsp_ready;
    logic [2*c_w-1:0] rsp_result;
    logic             rsp_in_perr, rsp_out_perr, rsp_timeout, spurious_out;

    logic m_dov, sp_dov;
    assign data_out_valid = m_dov | sp_dov;

    fifomult_driver #(.DATA_W(c_w), .TIMEOUT_CYCLES(c_to)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .req_a_perr(req_a_perr), .req_b_perr(req_b_perr),
        .data_in(data_in), .data_in_parity(data_in_parity),
        .data_in_valid(data_in_valid), .busy_out(busy_out),
        .data_out(data_out), .data_out_parity(data_out_parity),
        .data_out_valid(data_out_valid),
        .data_in_parity_error(data_in_parity_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_in_perr(rsp_in_perr),
        .rsp_out_perr(rsp_out_perr), .rsp_timeout(rsp_timeout),
        .spurious_out(spurious_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [c_w-1:0] d; logic p; bit is_b; } strobe_t;
    typedef struct { logic [2*c_w-1:0] result; logic in_perr, out_perr, timeout; } rsp_t;

    strobe_t st_sb[$];
    rsp_t    rsp_sb[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- multiplier model ----------------
    bit             m_respond = 1'b1;
    bit             m_badpar  = 1'b0;
    bit             m_have_a  = 1'b0;
    bit             m_pend    = 1'b0;
    logic [c_w-1:0] m_a;
    logic           m_pa;
    logic [2*c_w-1:0] m_res;
    logic           m_ierr;

    initial begin
        m_dov = 1'b0; data_out = '0; data_out_parity = 1'b0; data_in_parity_error = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_dov = 1'b0;
            if (m_pend) begin
                m_dov                = 1'b1;
                data_out             = m_res;
                data_out_parity      = m_badpar ? ~(^m_res) : ^m_res;
                data_in_parity_error = m_ierr;
                m_pend               = 1'b0;
            end
            if (data_in_valid) begin
                if (!m_have_a) begin
                    m_a = data_in; m_pa = data_in_parity; m_have_a = 1'b1;
                end else begin
                    m_have_a = 1'b0;
                    if (m_respond) begin
                        m_res  = 32'($signed({{c_w{m_a[c_w-1]}}, m_a}) *
                                     $signed({{c_w{data_in[c_w-1]}}, data_in}));
                        m_ierr = (m_pa != ^m_a) || (data_in_parity != ^data_in);
                        m_pend = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic busy_q = 1'b0;
    initial forever begin @(posedge clk); busy_q = busy_out; end

    int cyc = 0, acc_cyc = 0, b_cyc = 0, n_spur = 0;
    int exp_a_lat = 1, exp_rsp_lat = 2;
    logic prev_req_valid = 0, prev_req_ready = 0, prev_rst = 1;
    logic prev_rsp_valid = 0, prev_rsp_ready = 0;
    logic [2*c_w-1:0] prev_result = '0;
    logic [2:0] prev_flags = '0;

    initial begin
        strobe_t s;
        rsp_t    e;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_req_valid && prev_req_ready && !prev_rst) begin
                acc_cyc = cyc;
                chk("req_ready_drop", req_ready, 0);
            end
            if (data_in_valid) begin
                chk("strobe_busy_low", busy_q, 0);
                if (st_sb.size() == 0) chk("strobe_unexpected", st_sb.size(), 1);
                else begin
                    s = st_sb.pop_front();
                    chk(s.is_b ? "strobe_b_data" : "strobe_a_data", data_in, s.d);
                    chk(s.is_b ? "strobe_b_par" : "strobe_a_par", data_in_parity, s.p);
                    if (s.is_b) b_cyc = cyc;
                    else chk("a_latency", cyc - acc_cyc, exp_a_lat);
                end
            end
            if (rsp_valid && !prev_rsp_valid) chk("rsp_latency", cyc - b_cyc, exp_rsp_lat);
            if (prev_rsp_valid && !prev_rsp_ready && !prev_rst) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_result", rsp_result, prev_result);
                chk("rsp_hold_flags", {rsp_in_perr, rsp_out_perr, rsp_timeout}, prev_flags);
                chk("req_ready_in_resp", req_ready, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_sb.size() == 0) chk("rsp_unexpected", rsp_sb.size(), 1);
                else begin
                    e = rsp_sb.pop_front();
                    chk("rsp_result", rsp_result, e.result);
                    chk("rsp_in_perr", rsp_in_perr, e.in_perr);
                    chk("rsp_out_perr", rsp_out_perr, e.out_perr);
                    chk("rsp_timeout", rsp_timeout, e.timeout);
                end
            end
            if (spurious_out) n_spur++;
            prev_req_valid = req_valid;  prev_req_ready = req_ready;  prev_rst = rst;
            prev_rsp_valid = rsp_valid;  prev_rsp_ready = rsp_ready;
            prev_result    = rsp_result;
            prev_flags     = {rsp_in_perr, rsp_out_perr, rsp_timeout};
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_txn(input logic [c_w-1:0] a, input logic [c_w-1:0] b,
                          input bit ap, input bit bp, input bit respond,
                          input bit badpar, input int busy_n);
        int w;
        rsp_t e;
        logic signed [2*c_w-1:0] sa, sb;
        w = 0;
        while (!req_ready && w < 200) begin @(posedge clk); #1; w++; end
        if (!req_ready) chk("req_ready_wait", req_ready, 1);
        m_respond = respond;
        m_badpar  = badpar;
        exp_a_lat   = 1 + busy_n;
        exp_rsp_lat = respond ? 2 : c_to;
        st_sb.push_back('{d: a, p: (^a) ^ ap, is_b: 1'b0});
        st_sb.push_back('{d: b, p: (^b) ^ bp, is_b: 1'b1});
        sa = {{c_w{a[c_w-1]}}, a};
        sb = {{c_w{b[c_w-1]}}, b};
        if (respond) e = '{result: 32'(sa * sb), in_perr: ap | bp, out_perr: badpar, timeout: 1'b0};
        else         e = '{result: '0, in_perr: 1'b0, out_perr: 1'b0, timeout: 1'b1};
        rsp_sb.push_back(e);
        req_a = a; req_b = b; req_a_perr = ap; req_b_perr = bp; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (busy_n > 0) begin
            busy_out = 1'b1;
            repeat (busy_n) @(posedge clk);
            #1 busy_out = 1'b0;
        end
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((rsp_sb.size() != 0 || !req_ready) && w < 400) begin @(posedge clk); #1; w++; end
        chk("txn_done", rsp_sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
        req_a_perr = 1'b0; req_b_perr = 1'b0; busy_out = 1'b0;
        rsp_ready = 1'b1; sp_dov = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_data_in_valid", data_in_valid, 0);
        chk("reset_data_in", {data_in, data_in_parity}, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_result", rsp_result, 0);
        chk("reset_rsp_flags", {rsp_in_perr, rsp_out_perr, rsp_timeout}, 0);
        chk("reset_spurious", spurious_out, 0);

        do_txn(16'h0003, 16'hFFFE, 0, 0, 1, 0, 0);  wait_done();   // basic
        do_txn(16'h8000, 16'h8000, 0, 0, 1, 0, 0);  wait_done();   // corner
        do_txn(16'h8000, 16'h8000, 0, 0, 1, 1, 0);  wait_done();   // bad result parity
        do_txn(16'h7FFF, 16'h0002, 1, 0, 1, 0, 0);  wait_done();   // injection
        do_txn(16'h1234, 16'hA5A5, 0, 1, 1, 0, 0);  wait_done();   // B injection

        // backpressure: busy for 5 cycles, then response held 3 cycles
        rsp_ready = 1'b0;
        do_txn(16'h0005, 16'hFFF9, 0, 0, 1, 0, 5);
        w = 0;
        while (!rsp_valid && w < 200) begin @(posedge clk); #1; w++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (3) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done();

        // timeout
        do_txn(16'h0009, 16'h0009, 0, 0, 0, 0, 0);  wait_done();

        // spurious result strobe in IDLE
        sp_dov = 1'b1;
        @(posedge clk); #1 sp_dov = 1'b0;
        chk("spurious_pulse", spurious_out, 1);
        @(posedge clk); #1;
        chk("spurious_one_cycle", spurious_out, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("spurious_count", n_spur, 1);
        chk("spurious_no_rsp", rsp_valid, 0);

        // reset while waiting for a result
        do_txn(16'h0004, 16'h0004, 0, 0, 0, 0, 0);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_data_in_valid", data_in_valid, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        st_sb.delete();
        rsp_sb.delete();
        m_have_a = 1'b0;
        m_pend   = 1'b0;
        do_txn(16'h0001, 16'h0001, 0, 0, 1, 0, 0);  wait_done();

        repeat (5) @(posedge clk);
        #1;
        chk("strobe_sb_empty", st_sb.size(), 0);
        chk("final_spurious_count", n_spur, 1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
